multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Sequential main control unit for the multi-cycle RV32I core (next gen of the single-cycle decoder).
//  Sequences FETCH/DECODE/EXEC/MEM/WB per opcode and handshakes with instruction and data memories.
//  Emits datapath controls per state, retires instructions and counts them.
//  Enters sticky HALT/TRAP states on halt, illegal opcode or memory timeout.
// PARAMETERS
//  CNT_W        32   width of instret counter (wraps modulo 2^CNT_W)
//  MEM_TIMEOUT  16   max request cycles before ready must arrive; 0 = timeout disabled
//  TMO_W        $clog2(MEM_TIMEOUT+1) (localparam) wait-counter width
// PORTS
//  clk          in   1      core clock
//  reset        in   1      synchronous, active-high
//  Opcode       in   7      IR[6:0]; valid from DECODE onward
//  imem_req     out  1      instruction fetch request
//  imem_ready   in   1      fetch data valid this cycle
//  dmem_req     out  1      data access request
//  dmem_ready   in   1      data access complete this cycle
//  IRWrite      out  1      load IR (FETCH & imem_ready)
//  PCWrite      out  1      PC update strobe, last cycle of instr
//  ALUSrc, MemtoReg, JalrSel, jal_signal, lui_signal, auipc_signal, Branch  out 1 each  level controls
//  ALUOp        out  2      00 ld/st, 01 branch, 10 R/I, 11 jal/jalr
//  RegWrite     out  1      register-file write strobe (WB only)
//  MemRead, MemWrite  out 1 each  data strobes (MEM only)
//  instr_done   out  1      one-cycle retire pulse
//  instret      out  CNT_W  retired-instruction count
//  halted       out  1      sticky, HALT state
//  trap         out  1      sticky, TRAP state
//  trap_cause   out  2      00 none, 01 illegal, 10 imem tmo, 11 dmem tmo
// BEHAVIOUR
//  Reset: state=FETCH, op_q=0, wait_cnt=0, instret=0, trap_cause=00; all outputs 0 while reset high.
//  States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP (Moore, except IRWrite/strobe gating by ready).
//  FETCH: imem_req=1 held until imem_ready; IRWrite=imem_ready; -> DECODE on ready.
//  DECODE: op_q<=Opcode. HALT(1111111) -> HALT; unknown opcode -> TRAP cause 01; else -> EXEC.
//  Legal: 0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111.
//  Level controls from op_q per class table, driven only in EXEC/MEM/WB; 0 in FETCH/DECODE.
//   ALUSrc: LW,SW,I,JAL,JALR. Branch: BR,JAL,JALR. JalrSel: JALR. jal_signal: JAL,JALR.
//   MemtoReg: LW. lui_signal: LUI. auipc_signal: AUIPC.
//  EXEC -> MEM for LW/SW; -> FETCH for BR (retire); -> WB for all others.
//  MEM: dmem_req=1, MemRead(LW)/MemWrite(SW)=1 held until dmem_ready; on ready LW->WB, SW->FETCH (retire).
//  WB: RegWrite=1 one cycle -> FETCH (retire).
//  Retire cycle: PCWrite=1, instr_done=1, instret+=1 (wraps to 0 at 2^CNT_W-1).
//  Zero-wait latency: BR 3; SW,R,I,LUI,AUIPC,JAL,JALR 4; LW 5 cycles; +1 per wait cycle.
//  Timeout: wait_cnt counts req-high/ready-low cycles, clears on state entry. Ready low in request
//   cycle MEM_TIMEOUT -> TRAP (cause 10 FETCH, 11 MEM); ready in that cycle wins (normal advance).
//  HALT/TRAP: all req/strobes 0, instret frozen; only reset exits.
//  Reset mid-instruction: next state FETCH, no strobe or retire that cycle; aborted instr not counted.
//  Ready asserted with req low: ignored.
// STRUCTURE
//  rv_ctrl_pkg: opcode localparams, state_t enum, trap_cause_t enum, ctrl_t struct of level controls.
//  Sub-module mc_decode: combinational op_q -> ctrl_t + legal/halt flags; top holds FSM, timeout, instret.
// TESTING
//  ADD (0110011), zero wait -> IRWrite c1, RegWrite c4, PCWrite/instr_done c4, instret 0->1.
//  LW, dmem_ready after 3 wait cycles -> MemRead high 4 cycles, MemtoReg=1, RegWrite in WB; retire cycle 8.
//  BEQ then JALR -> BR retires cycle 3 with Branch=1 ALUOp=01 no RegWrite; JALR JalrSel=1 ALUOp=11 RegWrite.
//  MEM_TIMEOUT=4, imem_ready never -> imem_req 4 cycles, then trap=1 cause 10, outputs quiet.
//  Opcode 0000000 -> TRAP cause 01; opcode 1111111 -> halted=1, instret frozen; reset clears both.
//  CNT_W=4, retire 16 ADDs -> instret wraps 15->0; reset asserted in MEM of SW -> no MemWrite after, FETCH next.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and level-control bundle
// for the multi-cycle RV32I main control unit.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_JUMP  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        TC_NONE     = 2'b00,
        TC_ILLEGAL  = 2'b01,
        TC_IMEM_TMO = 2'b10,
        TC_DMEM_TMO = 2'b11
    } trap_cause_t;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       jalr_sel;
        logic       jal;
        logic       lui;
        logic       auipc;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: level controls plus the class flags
// the sequencer needs to pick its path through EXEC/MEM/WB.
module mc_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output ctrl_t      ctrl,
    output logic       legal,
    output logic       is_halt,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch
);

    always_comb begin
        ctrl      = '0;
        legal     = 1'b1;
        is_halt   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        case (op)
            OP_R: begin
                ctrl.alu_op = ALUOP_ARITH;
            end
            OP_I: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_ARITH;
            end
            OP_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALUOP_MEM;
                is_load         = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_MEM;
                is_store     = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
                is_branch   = 1'b1;
            end
            OP_JAL: begin
                ctrl.alu_src = 1'b1;
                ctrl.branch  = 1'b1;
                ctrl.jal     = 1'b1;
                ctrl.alu_op  = ALUOP_JUMP;
            end
            OP_JALR: begin
                ctrl.alu_src  = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.jal      = 1'b1;
                ctrl.jalr_sel = 1'b1;
                ctrl.alu_op   = ALUOP_JUMP;
            end
            OP_LUI: begin
                ctrl.lui = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.auipc = 1'b1;
            end
            // HALT is recognised separately; it never retires, so it is not "legal"
            OP_HALT: begin
                legal   = 1'b0;
                is_halt = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, request timeout, retire counting and sticky HALT/TRAP.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    input  logic             dmem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             JalrSel,
    output logic             jal_signal,
    output logic             lui_signal,
    output logic             auipc_signal,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    // Kept at least one bit wide so the disabled-timeout build still elaborates
    localparam int TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            state;
    logic [6:0]        op_q;
    logic [TMO_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  instret_q;
    trap_cause_t       cause_q;

    logic [6:0] dec_op;
    ctrl_t      dec_ctrl;
    logic       dec_legal, dec_halt, dec_load, dec_store, dec_branch;
    logic       wait_last;
    logic       retire;
    logic       active;
    ctrl_t      lv;

    // DECODE classifies the live IR bits; every later state uses the latched copy
    assign dec_op = (state == S_DECODE) ? Opcode : op_q;

    mc_decode u_decode (
        .op        (dec_op),
        .ctrl      (dec_ctrl),
        .legal     (dec_legal),
        .is_halt   (dec_halt),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .is_branch (dec_branch)
    );

    // True in the request cycle numbered MEM_TIMEOUT; a ready in that cycle still wins
    assign wait_last = (MEM_TIMEOUT != 0) && (wait_cnt == TMO_W'(MEM_TIMEOUT - 1));

    assign retire = !reset &&
                    (((state == S_EXEC) && dec_branch) ||
                     ((state == S_MEM) && dmem_ready && dec_store) ||
                     (state == S_WB));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            op_q      <= '0;
            wait_cnt  <= '0;
            instret_q <= '0;
            cause_q   <= TC_NONE;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_last) begin
                        state    <= S_TRAP;
                        cause_q  <= TC_IMEM_TMO;
                        wait_cnt <= '0;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q <= Opcode;
                    if (dec_halt) begin
                        state <= S_HALT;
                    end else if (!dec_legal) begin
                        state   <= S_TRAP;
                        cause_q <= TC_ILLEGAL;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dec_load || dec_store) state <= S_MEM;
                    else if (dec_branch)       state <= S_FETCH;
                    else                       state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state    <= dec_load ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (wait_last) begin
                        state    <= S_TRAP;
                        cause_q  <= TC_DMEM_TMO;
                        wait_cnt <= '0;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    // Everything is forced quiet while reset is held, even mid-instruction
    assign active = !reset && ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

    always_comb begin
        lv = '0;
        if (active) lv = dec_ctrl;
    end

    assign ALUSrc       = lv.alu_src;
    assign MemtoReg     = lv.mem_to_reg;
    assign JalrSel      = lv.jalr_sel;
    assign jal_signal   = lv.jal;
    assign lui_signal   = lv.lui;
    assign auipc_signal = lv.auipc;
    assign Branch       = lv.branch;
    assign ALUOp        = lv.alu_op;

    assign imem_req   = !reset && (state == S_FETCH);
    assign IRWrite    = imem_req && imem_ready;
    assign dmem_req   = !reset && (state == S_MEM);
    assign MemRead    = dmem_req && dec_load;
    assign MemWrite   = dmem_req && dec_store;
    assign RegWrite   = !reset && (state == S_WB);
    assign PCWrite    = retire;
    assign instr_done = retire;

    assign instret    = reset ? '0 : instret_q;
    assign halted     = !reset && (state == S_HALT);
    assign trap       = !reset && (state == S_TRAP);
    assign trap_cause = reset ? 2'b00 : cause_q;

endmodule
